// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe
// Registered RV32I instruction-decode stage between fetch and execute.
// Decodes the immediate and the packed control word, reads two operands
// from the register file (with optional same-cycle writeback bypass),
// detects load-use hazards and holds the result in a valid/ready ID/EX
// pipeline register.
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   if_valid/if_ready   fetch handshake; if_instr, if_pc instruction and PC
//   id_flush            discard the instruction presented in ID
//   wb_wr_en/addr/data  register file write port
//   ex_ready/ex_valid   execute handshake
//   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_rs_addr, ex_ctrl
//                       registered ID/EX contents
//   load_use_stall      load-use hazard stall this cycle (combinational)
//
// ex_ctrl packing: [15:12] alu_ctrl, [11] jalr, [10] jal, [9] branch,
// [8] memtoreg, [7] wb_reg_file, [6:5] mem_store_type, [4:2] mem_load_type,
// [1] mem_write, [0] alu_src.
// alu_ctrl codes: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra,
// 8 or, 9 and, 10 pass immediate (lui).
module decode_stage_pipe #(
  parameter int NUM_REGS       = 32,
  parameter bit WB_BYPASS      = 1'b1,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        id_flush,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_wr_addr,
  input  logic [31:0] wb_wr_data,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [9:0]  ex_rs_addr,
  output logic [15:0] ex_ctrl,
  output logic        load_use_stall
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm;
  logic [3:0]  w_alu_f3, w_alu;
  logic        w_jalr, w_jal, w_branch, w_memtoreg, w_wb, w_mw, w_src;
  logic [1:0]  w_st;
  logic [2:0]  w_ld;
  logic [15:0] w_ctrl;

  assign w_op  = if_instr[6:0];
  assign w_f3  = if_instr[14:12];
  assign w_rs1 = if_instr[19:15];
  assign w_rs2 = if_instr[24:20];
  assign w_rd  = if_instr[11:7];

  always_comb begin
    w_imm = '0;
    case (w_op)
      OP_IMM, OP_LOAD, OP_JALR: w_imm = {{20{if_instr[31]}}, if_instr[31:20]};
      OP_STORE:  w_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      OP_BRANCH: w_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                          if_instr[30:25], if_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: w_imm = {if_instr[31:12], 12'b0};
      OP_JAL:    w_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                          if_instr[20], if_instr[30:21], 1'b0};
      default:   w_imm = '0;
    endcase
  end

  // funct3 -> ALU op for register and immediate arithmetic; bit 30 selects
  // sub (register form only) and arithmetic shift right.
  always_comb begin
    w_alu_f3 = 4'd0;
    case (w_f3)
      3'd0: w_alu_f3 = (w_op == OP_REG && if_instr[30]) ? 4'd1 : 4'd0;
      3'd1: w_alu_f3 = 4'd2;
      3'd2: w_alu_f3 = 4'd3;
      3'd3: w_alu_f3 = 4'd4;
      3'd4: w_alu_f3 = 4'd5;
      3'd5: w_alu_f3 = if_instr[30] ? 4'd7 : 4'd6;
      3'd6: w_alu_f3 = 4'd8;
      default: w_alu_f3 = 4'd9;
    endcase
  end

  always_comb begin
    w_alu      = 4'd0;
    w_jalr     = 1'b0;
    w_jal      = 1'b0;
    w_branch   = 1'b0;
    w_memtoreg = 1'b0;
    w_wb       = 1'b0;
    w_st       = 2'd0;
    w_ld       = 3'd0;
    w_mw       = 1'b0;
    w_src      = 1'b0;
    case (w_op)
      OP_LUI:    begin w_alu = 4'd10; w_wb = 1'b1; w_src = 1'b1; end
      OP_AUIPC:  begin w_wb = 1'b1; w_src = 1'b1; end
      OP_JAL:    begin w_jal = 1'b1; w_wb = 1'b1; end
      OP_JALR:   begin w_jalr = 1'b1; w_wb = 1'b1; w_src = 1'b1; end
      OP_BRANCH: begin w_branch = 1'b1; w_alu = 4'd1; end
      OP_LOAD:   begin w_memtoreg = 1'b1; w_wb = 1'b1; w_src = 1'b1; w_ld = w_f3; end
      OP_STORE:  begin w_mw = 1'b1; w_src = 1'b1; w_st = w_f3[1:0]; end
      OP_IMM:    begin w_alu = w_alu_f3; w_wb = 1'b1; w_src = 1'b1; end
      OP_REG:    begin w_alu = w_alu_f3; w_wb = 1'b1; end
      default:   ;
    endcase
  end

  assign w_ctrl = {w_alu, w_jalr, w_jal, w_branch, w_memtoreg, w_wb,
                   w_st, w_ld, w_mw, w_src};

  // Register file: x0 has no storage, so it reads 0 and drops writes;
  // addresses at or above NUM_REGS never match a storage index.
  logic [31:0] r_regs [NUM_REGS-1:1];
  logic [31:0] w_rf_rs1, w_rf_rs2, w_rs1_data, w_rs2_data;
  logic        w_wb_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_wr_en) begin
      for (int i = 1; i < NUM_REGS; i++)
        if (wb_wr_addr == 5'(i)) r_regs[i] <= wb_wr_data;
    end
  end

  always_comb begin
    w_rf_rs1 = '0;
    w_rf_rs2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (w_rs1 == 5'(i)) w_rf_rs1 = r_regs[i];
      if (w_rs2 == 5'(i)) w_rf_rs2 = r_regs[i];
    end
  end

  // A bypass only applies to writes that will actually land in storage.
  assign w_wb_hit   = WB_BYPASS && wb_wr_en && (wb_wr_addr != 5'd0) &&
                      ({1'b0, wb_wr_addr} < 6'(NUM_REGS));
  assign w_rs1_data = (w_wb_hit && wb_wr_addr == w_rs1) ? wb_wr_data : w_rf_rs1;
  assign w_rs2_data = (w_wb_hit && wb_wr_addr == w_rs2) ? wb_wr_data : w_rf_rs2;

  // ID/EX register
  logic        r_valid;
  logic [31:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]  r_rd;
  logic [9:0]  r_rs_addr;
  logic [15:0] r_ctrl;
  logic        w_hazard, w_load, w_new_valid;

  // Source compare ignores the format, so some non-users of rs2 stall too.
  assign w_hazard    = LOAD_USE_STALL && r_valid && r_ctrl[8] && (r_rd != 5'd0) &&
                       ((r_rd == w_rs1) || (r_rd == w_rs2));
  assign w_load      = !r_valid || ex_ready;
  assign w_new_valid = if_valid && !w_hazard && !id_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_rs_addr  <= '0;
      r_ctrl     <= '0;
    end else if (w_load) begin
      r_valid    <= w_new_valid;
      r_pc       <= if_pc;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rs_addr  <= {w_rs2, w_rs1};
      r_rd       <= w_new_valid ? w_rd : 5'd0;
      r_ctrl     <= w_new_valid ? w_ctrl : 16'd0;
    end
  end

  assign if_ready       = w_load && !w_hazard;
  assign load_use_stall = w_hazard && if_valid;
  assign ex_valid       = r_valid;
  assign ex_pc          = r_pc;
  assign ex_rs1_data    = r_rs1_data;
  assign ex_rs2_data    = r_rs2_data;
  assign ex_imm         = r_imm;
  assign ex_rd          = r_rd;
  assign ex_rs_addr     = r_rs_addr;
  assign ex_ctrl        = r_ctrl;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe. Four instances share one stimulus stream:
//   0: 32 regs, bypass, stall   1: 32 regs, no bypass, stall
//   2: 16 regs, bypass, stall   3: 32 regs, bypass, no stall
module tb_decode_stage_pipe;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_valid, id_flush, wb_wr_en, ex_ready;
  logic [31:0] if_instr, if_pc, wb_wr_data;
  logic [4:0]  wb_wr_addr;

  logic        o_if_ready [NI];
  logic        o_valid    [NI];
  logic        o_lus      [NI];
  logic [31:0] o_pc       [NI];
  logic [31:0] o_rs1      [NI];
  logic [31:0] o_rs2      [NI];
  logic [31:0] o_imm      [NI];
  logic [4:0]  o_rd       [NI];
  logic [9:0]  o_rsa      [NI];
  logic [15:0] o_ctrl     [NI];

  int n_total = 0;
  int n_bad   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    decode_stage_pipe #(
      .NUM_REGS      ((g == 2) ? 16 : 32),
      .WB_BYPASS     (g != 1),
      .LOAD_USE_STALL(g != 3)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .if_valid      (if_valid),
      .if_ready      (o_if_ready[g]),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .id_flush      (id_flush),
      .wb_wr_en      (wb_wr_en),
      .wb_wr_addr    (wb_wr_addr),
      .wb_wr_data    (wb_wr_data),
      .ex_ready      (ex_ready),
      .ex_valid      (o_valid[g]),
      .ex_pc         (o_pc[g]),
      .ex_rs1_data   (o_rs1[g]),
      .ex_rs2_data   (o_rs2[g]),
      .ex_imm        (o_imm[g]),
      .ex_rd         (o_rd[g]),
      .ex_rs_addr    (o_rsa[g]),
      .ex_ctrl       (o_ctrl[g]),
      .load_use_stall(o_lus[g])
    );
  end

  function automatic int  np (int k); return (k == 2) ? 16 : 32; endfunction
  function automatic bit  bp (int k); return k != 1; endfunction
  function automatic bit  lus(int k); return k != 3; endfunction
  function automatic string tg(int k, string s); return $sformatf("i%0d.%s", k, s); endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_regs [NI][32];
  bit          m_valid[NI];
  logic [31:0] m_pc[NI], m_a[NI], m_b[NI], m_imm[NI];
  logic [4:0]  m_rd[NI];
  logic [9:0]  m_rsa[NI];
  logic [15:0] m_ctrl[NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int r = 0; r < 32; r++) m_regs[k][r] = '0;
      m_valid[k] = 1'b0; m_pc[k] = '0; m_a[k] = '0; m_b[k] = '0;
      m_imm[k] = '0; m_rd[k] = '0; m_rsa[k] = '0; m_ctrl[k] = '0;
    end
  endtask

  // Returns {imm, ctrl} computed from the RV32I field definitions.
  function automatic logic [47:0] ref_dec(logic [31:0] ins);
    int         imm = 0;
    int         iimm, simm;
    logic [3:0] alu = 4'd0;
    bit         jalr = 0, jal = 0, br = 0, m2r = 0, wb = 0, mw = 0, src = 0;
    logic [1:0] st = 2'd0;
    logic [2:0] ldt = 3'd0;
    logic [2:0] f3;
    logic [3:0] f3map [8];
    f3map = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    f3   = ins[14:12];
    iimm = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
    simm = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
    case (ins[6:0])
      7'h37: begin imm = int'(ins[31:12]) * 4096; alu = 4'd10; wb = 1; src = 1; end
      7'h17: begin imm = int'(ins[31:12]) * 4096; wb = 1; src = 1; end
      7'h6F: begin
        imm = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
              - (ins[31] ? (1 << 20) : 0);
        jal = 1; wb = 1;
      end
      7'h67: begin imm = iimm; jalr = 1; wb = 1; src = 1; end
      7'h63: begin
        imm = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
              - (ins[31] ? 4096 : 0);
        br = 1; alu = 4'd1;
      end
      7'h03: begin imm = iimm; m2r = 1; wb = 1; src = 1; ldt = f3; end
      7'h23: begin imm = simm; mw = 1; src = 1; st = f3[1:0]; end
      7'h13: begin
        imm = iimm; wb = 1; src = 1; alu = f3map[f3];
        if (f3 == 3'd5 && ins[30]) alu = 4'd7;
      end
      7'h33: begin
        wb = 1; alu = f3map[f3];
        if (f3 == 3'd5 && ins[30]) alu = 4'd7;
        if (f3 == 3'd0 && ins[30]) alu = 4'd1;
      end
      default: ;
    endcase
    return {32'(imm), alu, jalr, jal, br, m2r, wb, st, ldt, mw, src};
  endfunction

  function automatic logic [31:0] ref_read(int k, logic [4:0] a);
    if (a == 5'd0 || int'(a) >= np(k)) return 32'd0;
    if (bp(k) && wb_wr_en && wb_wr_addr == a) return wb_wr_data;
    return m_regs[k][a];
  endfunction

  // Check all instances against the model for the current inputs, then
  // advance one clock and update the model. Returns at the falling edge.
  task automatic cycle();
    logic [47:0] d;
    logic [4:0]  rs1, rs2;
    bit          haz;
    bit          ld_a[NI], nv_a[NI];
    logic [31:0] n_a[NI], n_b[NI];
    #1;
    rs1 = if_instr[19:15];
    rs2 = if_instr[24:20];
    d   = ref_dec(if_instr);
    for (int k = 0; k < NI; k++) begin
      haz = lus(k) && m_valid[k] && m_ctrl[k][8] && m_rd[k] != 5'd0 &&
            (m_rd[k] == rs1 || m_rd[k] == rs2);
      ld_a[k] = !m_valid[k] || ex_ready;
      chk(tg(k, "if_ready"), o_if_ready[k], ld_a[k] && !haz);
      chk(tg(k, "stall"),    o_lus[k],      haz && if_valid);
      chk(tg(k, "valid"),    o_valid[k],    m_valid[k]);
      chk(tg(k, "rd"),       o_rd[k],       m_rd[k]);
      chk(tg(k, "ctrl"),     o_ctrl[k],     m_ctrl[k]);
      if (m_valid[k]) begin
        chk(tg(k, "pc"),  o_pc[k],  m_pc[k]);
        chk(tg(k, "rs1"), o_rs1[k], m_a[k]);
        chk(tg(k, "rs2"), o_rs2[k], m_b[k]);
        chk(tg(k, "imm"), o_imm[k], m_imm[k]);
        chk(tg(k, "rsa"), o_rsa[k], m_rsa[k]);
      end
      nv_a[k] = if_valid && !haz && !id_flush;
      n_a[k]  = ref_read(k, rs1);
      n_b[k]  = ref_read(k, rs2);
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (ld_a[k]) begin
        m_valid[k] = nv_a[k];
        m_pc[k]    = if_pc;
        m_a[k]     = n_a[k];
        m_b[k]     = n_b[k];
        m_imm[k]   = d[47:16];
        m_rsa[k]   = {rs2, rs1};
        m_rd[k]    = nv_a[k] ? if_instr[11:7] : 5'd0;
        m_ctrl[k]  = nv_a[k] ? d[15:0] : 16'd0;
      end
      if (wb_wr_en && wb_wr_addr != 5'd0 && int'(wb_wr_addr) < np(k))
        m_regs[k][wb_wr_addr] = wb_wr_data;
    end
    @(negedge clk);
  endtask

  task automatic reset_check();
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk(tg(k, "rst.valid"), o_valid[k], 0);
      chk(tg(k, "rst.pc"),    o_pc[k],    0);
      chk(tg(k, "rst.rs1"),   o_rs1[k],   0);
      chk(tg(k, "rst.rs2"),   o_rs2[k],   0);
      chk(tg(k, "rst.imm"),   o_imm[k],   0);
      chk(tg(k, "rst.rd"),    o_rd[k],    0);
      chk(tg(k, "rst.rsa"),   o_rsa[k],   0);
      chk(tg(k, "rst.ctrl"),  o_ctrl[k],  0);
      chk(tg(k, "rst.ready"), o_if_ready[k], 1);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_if(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid = v; if_instr = ins; if_pc = pc;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] dat);
    wb_wr_en = en; wb_wr_addr = a; wb_wr_data = dat;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom();
    case ($urandom_range(0, 9))
      0: x[6:0] = 7'h37;
      1: x[6:0] = 7'h17;
      2: x[6:0] = 7'h6F;
      3: x[6:0] = 7'h67;
      4: x[6:0] = 7'h63;
      5: x[6:0] = 7'h03;
      6: x[6:0] = 7'h23;
      7: x[6:0] = 7'h13;
      8: x[6:0] = 7'h33;
      default: x[6:0] = 7'h7F;
    endcase
    if ($urandom_range(0, 3) != 0) begin
      x[19:15] = 5'($urandom_range(0, 7));
      x[24:20] = 5'($urandom_range(0, 7));
      x[11:7]  = 5'($urandom_range(0, 7));
    end
    return x;
  endfunction

  initial begin
    set_if(0, 0, 0);
    set_wb(0, 0, 0);
    id_flush = 1'b0;
    ex_ready = 1'b1;
    model_reset();
    reset_check();

    // x0 ignores writes and reads 0
    set_if(1, 32'h0000_02B3, 32'h100);
    set_wb(1, 5'd0, 32'hDEAD_BEEF);
    cycle();
    chk("x0.valid", o_valid[0], 1);
    chk("x0.rs1",   o_rs1[0],   0);
    chk("x0.rs2",   o_rs2[0],   0);

    // same-cycle writeback bypass
    set_if(0, 0, 0);
    set_wb(1, 5'd3, 32'h1111_1111);
    cycle();
    set_if(1, 32'h0011_8213, 32'h104);
    set_wb(1, 5'd3, 32'h1234_5678);
    cycle();
    chk("byp.rs1",   o_rs1[0], 32'h1234_5678);
    chk("nobyp.rs1", o_rs1[1], 32'h1111_1111);
    chk("byp.imm",   o_imm[0], 32'd1);
    chk("byp.src",   o_ctrl[0][0], 1);

    // load-use: LW x6 then ADD x7,x6,x2
    set_wb(0, 0, 0);
    set_if(1, 32'h0000_A303, 32'h108);
    cycle();
    set_if(1, 32'h0023_03B3, 32'h10C);
    #1;
    chk("lu.stall", o_lus[0], 1);
    chk("lu.ready", o_if_ready[0], 0);
    chk("lu.nostall3", o_lus[3], 0);
    cycle();
    chk("lu.bubble", o_valid[0], 0);
    chk("lu.ctrl",   o_ctrl[0],  0);
    #1;
    chk("lu.ready2", o_if_ready[0], 1);
    cycle();
    chk("lu.valid", o_valid[0], 1);
    chk("lu.rd",    o_rd[0],    5'd7);
    chk("lu.pc",    o_pc[0],    32'h10C);

    // flush: branch in EX, SW presented and killed
    set_if(1, 32'h0000_0063, 32'h110);
    cycle();
    set_if(1, 32'h0020_A023, 32'h114);
    id_flush = 1'b1;
    #1;
    chk("fl.ready", o_if_ready[0], 1);
    cycle();
    id_flush = 1'b0;
    chk("fl.valid", o_valid[0], 0);
    chk("fl.mw",    o_ctrl[0][1], 0);

    // back-pressure for three cycles with a flush pulse in the middle
    set_if(1, 32'h0023_03B3, 32'h118);
    cycle();
    ex_ready = 1'b0;
    set_if(1, 32'h0041_8213, 32'h11C);
    for (int c = 0; c < 3; c++) begin
      id_flush = (c == 1);
      #1;
      chk("bp.ready", o_if_ready[0], 0);
      cycle();
      chk("bp.valid", o_valid[0], 1);
      chk("bp.pc",    o_pc[0],    32'h118);
      chk("bp.rd",    o_rd[0],    5'd7);
      chk("bp.ctrl",  o_ctrl[0],  16'h0080);
      chk("bp.rs1",   o_rs1[0],   m_a[0]);
    end
    id_flush = 1'b0;
    ex_ready = 1'b1;
    #1;
    chk("bp.release", o_if_ready[0], 1);
    cycle();
    chk("bp.next.pc", o_pc[0], 32'h11C);

    // RV32E: x20 is outside the file, x15 is inside
    set_if(0, 0, 0);
    set_wb(1, 5'd20, 32'd5);
    cycle();
    set_wb(1, 5'd15, 32'd5);
    cycle();
    set_wb(0, 0, 0);
    set_if(1, 32'h00FA_0433, 32'h120);
    cycle();
    chk("e.x20",    o_rs1[2], 0);
    chk("e.x15",    o_rs2[2], 32'd5);
    chk("full.x20", o_rs1[0], 32'd5);

    // randomized traffic with a mid-stream reset
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) reset_check();
      set_if($urandom_range(0, 3) != 0, rand_instr(), $urandom());
      id_flush = ($urandom_range(0, 7) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      set_wb($urandom_range(0, 1) != 0,
             ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom()),
             $urandom());
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Registered instruction-decode stage for the RV32I core. It sits between fetch and execute. It absorbs the existing immediate decode and control decode, plus a parametrised register file with optional writeback bypass. It adds a valid/ready ID/EX pipeline register, load-use hazard stall and flush-to-bubble, replacing the flow-through decode path.

## Interface
- NUM_REGS, 32, architectural registers (16 for RV32E or 32); register addresses >= NUM_REGS read 0 and writes to them are ignored
- WB_BYPASS, 1, 1 = a same-cycle WB write to a source register is forwarded to the read data; 0 = the read returns the pre-write value
- LOAD_USE_STALL, 1, 1 = detect load-use hazards and insert a bubble; 0 = no detection, external logic owns the hazard

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  instruction PC
- id_flush  in  1  kill the instruction currently presented in ID
- wb_wr_en  in  1  register file write enable
- wb_wr_addr  in  5  write address
- wb_wr_data  in  32  write data
- ex_ready  in  1  execute stage consumes the ID/EX contents
- ex_valid  out  1  ID/EX register holds a live instruction
- ex_pc  out  32  registered PC
- ex_rs1_data  out  32  registered rs1 operand
- ex_rs2_data  out  32  registered rs2 operand
- ex_imm  out  32  registered immediate
- ex_rd  out  5  registered destination, instr[11:7]
- ex_rs_addr  out  10  registered {rs2, rs1}, for the EX forwarding unit
- ex_ctrl  out  16  packed control: [15:12] alu_ctrl, [11] jalr, [10] jal, [9] branch, [8] memtoreg, [7] wb_reg_file, [6:5] mem_store_type, [4:2] mem_load_type, [1] mem_write, [0] alu_src
- load_use_stall  out  1  hazard stall asserted this cycle (combinational)

## Operation
- **Decode.**
  - rs1 = if_instr[19:15], rs2 = if_instr[24:20].
  - The immediate and the 16 control bits come from the existing decode_unit and control_unit, combinationally.
- **Register file.**
  - NUM_REGS x 32 flops, written on the rising clk edge when wb_wr_en is set and wb_wr_addr is nonzero and below NUM_REGS.
  - x0 always reads 0; writes to x0 are dropped.
  - Two combinational read ports.
- **Bypass.** When WB_BYPASS=1, wb_wr_en is set and wb_wr_addr == rs (rs nonzero), the read data for that port is wb_wr_data.
- **Hazard.** hazard = LOAD_USE_STALL & ex_valid & ex_ctrl[8] & (ex_rd != 0) & (ex_rd == rs1 | ex_rd == rs2).
  - The comparison is format-agnostic (conservative).
  - load_use_stall = hazard & if_valid.
- **Load enable.** load = !ex_valid | ex_ready.
- **if_ready** = load & !hazard.
- **On a clock edge with load = 1:**
  - ex_valid <= if_valid & !hazard & !id_flush.
  - When the new ex_valid is 1: the data fields and ex_ctrl are captured from ID.
  - When the new ex_valid is 0 (bubble): ex_ctrl <= 0, ex_rd <= 0. Data fields are captured but are don't-care.
- **With load = 0:** all ID/EX contents hold, including during id_flush, so the branch being resolved in EX is never killed.
- **id_flush with load = 1:** the presented instruction is consumed (if_ready follows the rule above) and discarded.
- **Simultaneous hazard and flush:** a bubble is loaded; if_ready = 0.

## Timing
- **Reset:** ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_rs_addr, ex_ctrl and all registers go to 0 immediately.
  - if_ready settles to 1 combinationally.
  - A reset mid-transaction discards the ID/EX contents.
- **Latency:** 1 cycle from acceptance (if_valid & if_ready at an edge) to ex_valid high.
- **Throughput:** 1 instruction/cycle while ex_ready = 1 and no hazard.
- **Load-use:** exactly one bubble per hazard. The dependent instruction is held by fetch (if_ready = 0), then accepted on the following cycle.
- **Write then read:**
  - A write at edge N is visible to reads after edge N.
  - With WB_BYPASS=1 it is also visible in the cycle before edge N.
- **Back-pressure:** ex_ready = 0 with ex_valid = 1 holds every output stable and forces if_ready = 0.

## Test plan
- **Reset and x0.** Assert rst mid-stream -> all outputs 0 immediately. WB write x0 = 0xDEADBEEF, then issue ADD x5,x0,x0 -> ex_rs1_data = ex_rs2_data = 0.
- **Bypass.** WB writes x3 = 0x12345678 in the same cycle ID presents ADDI x4,x3,1 -> ex_rs1_data = 0x12345678 with WB_BYPASS=1, old value with WB_BYPASS=0. ex_imm = 1; ex_ctrl[0] = 1.
- **Load-use.** LW x6,0(x1) followed by ADD x7,x6,x2 -> one cycle with load_use_stall = 1, if_ready = 0, ex_valid = 0 (ex_ctrl = 0). ADD reaches EX on the next cycle.
- **Flush.** Branch in EX, id_flush = 1 with SW presented and ex_ready = 1 -> next cycle ex_valid = 0, ex_ctrl[1] = 0, fetch advances.
- **Back-pressure.** ex_ready = 0 for 3 cycles with ex_valid = 1 and id_flush pulsed -> ex_* outputs unchanged, if_ready = 0 throughout. Release -> next instruction is accepted.
- **RV32E.** With NUM_REGS=16: write x20 = 5 and read x20 -> reads 0. Write x15 = 5 -> reads 5.
